// File: rtl/mtm_alu_pkt_rx.sv
// Serial frame receiver for the MTM ALU: collects DATA bytes into operands and emits a result on CTL.
// Define MTM_ALU_PKT_RX_CRC_EN to build the CRC-4 check on the CTL byte.
module mtm_alu_pkt_rx #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_OPS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sin,
  output logic [N_OPS*DATA_W-1:0]   op_data,
  output logic [2:0]                op_code,
  output logic [1:0]                err_flags,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                ovr_cnt
);

  localparam int unsigned W  = N_OPS * DATA_W;
  localparam int unsigned NB = W / 8;
  localparam int unsigned CW = $clog2(NB + 2);

  typedef enum logic [1:0] {StIdle, StType, StPayload, StStop} state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            is_ctl_q, is_ctl_d;
  logic [7:0]      byte_q, byte_d;
  logic            hold_q, hold_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [W-1:0]    shift_q, shift_d;

  logic            res_vld;
  logic [W-1:0]    res_data;
  logic [2:0]      res_code;
  logic [1:0]      res_err;

`ifdef MTM_ALU_PKT_RX_CRC_EN
  logic [3:0]      crc_q, crc_d;

  // Serial CRC-4, x^4+x+1, one message bit per step.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:1], c[0] ^ fb, fb};
  endfunction

  function automatic logic [3:0] crc_bits(input logic [3:0] c, input logic [7:0] v,
                                          input int unsigned n);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (i < int'(n)) r = crc_bit(r, v[i]);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    is_ctl_d   = is_ctl_q;
    byte_d     = byte_q;
    hold_d     = hold_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
`ifdef MTM_ALU_PKT_RX_CRC_EN
    crc_d      = crc_q;
`endif
    res_vld    = 1'b0;
    res_data   = '0;
    res_code   = '0;
    res_err    = '0;
    case (state_q)
      StIdle: begin
        // After an aborted frame a start bit is only honoured once sin has been high.
        if (sin) hold_d = 1'b0;
        else if (!hold_q) state_d = StType;
      end
      StType: begin
        is_ctl_d  = sin;
        bit_cnt_d = '0;
        state_d   = StPayload;
      end
      StPayload: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StStop;
      end
      StStop: begin
        state_d = StIdle;
        if (!sin) begin
          hold_d     = 1'b1;
          byte_cnt_d = '0;
          shift_d    = '0;
`ifdef MTM_ALU_PKT_RX_CRC_EN
          crc_d      = '0;
`endif
        end else if (!is_ctl_q) begin
          shift_d = (shift_q << 8) | W'(byte_q);
          if (byte_cnt_q != CW'(NB + 1)) byte_cnt_d = byte_cnt_q + CW'(1);
`ifdef MTM_ALU_PKT_RX_CRC_EN
          crc_d = crc_bits(crc_q, byte_q, 8);
`endif
        end else begin
          res_vld = 1'b1;
          if (byte_cnt_q != CW'(NB) || byte_q[7]) begin
            res_err = 2'b10;
`ifdef MTM_ALU_PKT_RX_CRC_EN
          end else if (crc_bits(crc_q, {1'b0, byte_q[6:4], 4'h0}, 7) != byte_q[3:0]) begin
            res_err = 2'b01;
`endif
          end else begin
            res_data = shift_q;
            res_code = byte_q[6:4];
          end
          byte_cnt_d = '0;
          shift_d    = '0;
`ifdef MTM_ALU_PKT_RX_CRC_EN
          crc_d      = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      is_ctl_q   <= 1'b0;
      byte_q     <= '0;
      hold_q     <= 1'b0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
`ifdef MTM_ALU_PKT_RX_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      is_ctl_q   <= is_ctl_d;
      byte_q     <= byte_d;
      hold_q     <= hold_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
`ifdef MTM_ALU_PKT_RX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  // A result arriving while the previous one is still unaccepted is dropped and counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_data   <= '0;
      op_code   <= '0;
      err_flags <= '0;
      out_valid <= 1'b0;
      ovr_cnt   <= '0;
    end else if (res_vld) begin
      if (out_valid && !out_ready) begin
        if (ovr_cnt != 8'hff) ovr_cnt <= ovr_cnt + 8'd1;
      end else begin
        op_data   <= res_data;
        op_code   <= res_code;
        err_flags <= res_err;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
